seq_acc_alu: RTL and testbench

SEQ_ACC_ALU -- requirements
Module: seq_acc_alu

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/shift_add_mul.sv | 71 +++++++
 rtl/seq_acc_alu.sv | 139 +++++++++++++
 tb/tb_seq_acc_alu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// ---------------------------------------------------------------------------
// seq_alu_pkg
// Shared encodings for the sequential accumulator ALU.
//   opcode_e : command opcodes carried on the 3-bit opcode port
//   state_e  : control FSM states of seq_acc_alu
// ---------------------------------------------------------------------------
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_CLR  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned shift-add multiplier, one multiplier bit per enabled
// cycle, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset (control state only)
//   start      : load mcand/mplier and begin a new product
//   step       : advance one iteration when busy
//   mcand      : multiplicand (WIDTH bits)
//   mplier     : multiplier   (WIDTH bits)
//   busy       : iteration in progress
//   last       : the current iteration is the final one
//   product    : partial product including the current iteration's term;
//                equals the full 2*WIDTH-bit product while busy && last
// ---------------------------------------------------------------------------
module shift_add_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand_sh;
  logic [2*WIDTH-1:0] part;
  logic [WIDTH-1:0]   mplier_sh;
  logic [CNT_W-1:0]   cnt;

  // Exposing the next partial product lets the owner capture the result on
  // the same edge as the final iteration instead of one cycle later.
  assign product = part + (mplier_sh[0] ? mcand_sh : '0);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  // Control: busy flag and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy && step) begin
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

  // Datapath: shifted operands and running partial product
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_sh  <= {{WIDTH{1'b0}}, mcand};
      mplier_sh <= mplier;
      part      <= '0;
    end else if (busy && step) begin
      part      <= product;
      mcand_sh  <= mcand_sh << 1;
      mplier_sh <= mplier_sh >> 1;
    end
  end

endmodule

// File: rtl/seq_acc_alu.sv
// ---------------------------------------------------------------------------
// seq_acc_alu
// Accumulator ALU with a single-command handshake. Logic/arithmetic ops
// complete on the accept edge; MUL runs an iterative shift-add multiplier.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   ena       : design enable; pauses acceptance and multiplication
//   in_valid  : command presented
//   in_ready  : command can be accepted (IDLE and enabled)
//   opcode    : operation select (seq_alu_pkg::opcode_e)
//   operand   : second operand
//   acc_out   : accumulator register
//   done      : one-cycle completion pulse
//   flag_z    : accumulator is zero after the last command
//   flag_c    : ADD carry / SUB borrow
//   flag_v    : MUL product overflowed WIDTH bits
// ---------------------------------------------------------------------------
module seq_acc_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  // Single-cycle ops: result in the low WIDTH bits, carry/borrow on top.
  // Non-ADD/SUB ops leave the top bit clear so flag_c is cleared by them.
  function automatic logic [WIDTH:0] alu_eval(input opcode_e op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_LOAD: r = {1'b0, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      // Extending by one bit makes the top bit the borrow (b > a).
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e               state;
  logic [WIDTH-1:0]     acc;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_product;
  logic [WIDTH:0]       alu_res;
  opcode_e              op;

  assign op        = opcode_e'(opcode);
  assign in_ready  = (state == ST_IDLE) && ena;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign alu_res   = alu_eval(op, acc, operand);
  assign acc_out   = acc;

  shift_add_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .step    (ena),
    .mcand   (acc),
    .mplier  (operand),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  // Control FSM, accumulator and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            if (op == OP_MUL) begin
              state <= ST_MUL_RUN;
            end else begin
              state  <= ST_DONE;
              done   <= 1'b1;
              acc    <= alu_res[WIDTH-1:0];
              flag_c <= alu_res[WIDTH];
              flag_z <= (alu_res[WIDTH-1:0] == '0);
              flag_v <= 1'b0;
            end
          end
        end
        ST_MUL_RUN: begin
          // acc stays at the multiplicand until the final iteration edge.
          if (ena && mul_busy && mul_last) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            acc    <= mul_product[WIDTH-1:0];
            flag_z <= (mul_product[WIDTH-1:0] == '0);
            flag_c <= 1'b0;
            flag_v <= |mul_product[2*WIDTH-1:WIDTH];
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_acc_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_acc_alu
// Self-checking bench for seq_acc_alu (WIDTH=8): directed scenarios followed
// by random commands, compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_acc_alu;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] operand;
  logic [W-1:0] acc_out;
  logic         done;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int acc_m;
  bit z_m, c_m, v_m;

  always #5 clk = ~clk;

  seq_acc_alu #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .operand  (operand),
    .acc_out  (acc_out),
    .done     (done),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input int op, input int val);
    int p;
    case (op)
      0: begin acc_m = val; c_m = 0; v_m = 0; end
      1: begin p = acc_m + val; c_m = (p >= MOD); acc_m = p % MOD; v_m = 0; end
      2: begin c_m = (val > acc_m); acc_m = (acc_m - val + MOD) % MOD; v_m = 0; end
      3: begin acc_m = acc_m & val; c_m = 0; v_m = 0; end
      4: begin acc_m = acc_m | val; c_m = 0; v_m = 0; end
      5: begin acc_m = acc_m ^ val; c_m = 0; v_m = 0; end
      6: begin p = acc_m * val; v_m = (p >= MOD); acc_m = p % MOD; c_m = 0; end
      default: begin acc_m = 0; c_m = 0; v_m = 0; end
    endcase
    z_m = (acc_m == 0);
  endtask

  // Issue one command and follow it to its done pulse.
  // pause_at >= 0 drops ena for 3 cycles starting that many cycles after accept.
  // hold keeps in_valid high (with a LOAD 0x55) while the command is busy.
  task automatic run_cmd(input int op, input int val, input int pause_at, input bit hold);
    int pre_m;
    int lat;
    int exp_lat;
    bit seen;
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    opcode   = op[2:0];
    operand  = val[W-1:0];
    pre_m    = acc_m;
    model_apply(op, val);
    exp_lat = (op == 6) ? W + 1 : 1;
    if (pause_at >= 0 && op == 6) exp_lat += 3;
    @(posedge clk);
    #1;
    if (hold) begin
      opcode  = 3'd0;
      operand = 8'h55;
    end else begin
      in_valid = 1'b0;
    end
    lat  = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (op == 6 && pause_at >= 0 && lat == pause_at) ena = 1'b0;
      if (op == 6 && pause_at >= 0 && lat == pause_at + 3) ena = 1'b1;
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        chk("busy_ready", in_ready, 0);
        chk("acc_hold", acc_out, pre_m);
      end
    end
    in_valid = 1'b0;
    ena      = 1'b1;
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat);
    chk("acc", acc_out, acc_m);
    chk("flag_z", flag_z, z_m);
    chk("flag_c", flag_c, c_m);
    chk("flag_v", flag_v, v_m);
    chk("ready_at_done", in_ready, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_after", in_ready, 1);
    chk("acc_after", acc_out, acc_m);
  endtask

  initial begin
    int op;
    int val;
    int pa;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    opcode   = 3'd0;
    operand  = '0;
    acc_m = 0; z_m = 0; c_m = 0; v_m = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_acc", acc_out, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {flag_z, flag_c, flag_v}, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // Add without and with carry out
    run_cmd(0, 'h7F, -1, 0);
    run_cmd(1, 'h01, -1, 0);
    run_cmd(0, 'hFF, -1, 0);
    run_cmd(1, 'h01, -1, 0);

    // Borrow, logic ops, zero result
    run_cmd(0, 'h05, -1, 0);
    run_cmd(2, 'h07, -1, 0);
    run_cmd(0, 'h0C, -1, 0);
    run_cmd(3, 'h0A, -1, 0);
    run_cmd(5, 'h08, -1, 0);
    run_cmd(0, 'h30, -1, 0);
    run_cmd(4, 'h03, -1, 0);
    run_cmd(7, 'hA5, -1, 0);

    // Multiply without and with overflow
    run_cmd(0, 'h0D, -1, 0);
    run_cmd(6, 'h0B, -1, 0);
    run_cmd(0, 'h20, -1, 0);
    run_cmd(6, 'h10, -1, 0);

    // Multiply paused by ena for 3 cycles, in_valid held high while busy
    run_cmd(0, 'h0D, -1, 0);
    run_cmd(6, 'h0B, 3, 1);

    // ena low in IDLE: a presented command is not accepted
    @(negedge clk);
    ena      = 1'b0;
    in_valid = 1'b1;
    opcode   = 3'd0;
    operand  = 8'h99;
    repeat (2) begin
      @(negedge clk);
      chk("ena_low_ready", in_ready, 0);
      chk("ena_low_done", done, 0);
      chk("ena_low_acc", acc_out, acc_m);
    end
    in_valid = 1'b0;
    ena      = 1'b1;

    // Reset asserted mid-multiply aborts with no done pulse
    run_cmd(0, 'h33, -1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 3'd6;
    operand  = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("pre_rst_done", done, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_flags", {flag_z, flag_c, flag_v}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0; z_m = 0; c_m = 0; v_m = 0;
    repeat (W + 2) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_acc", acc_out, 0);
    end

    // Random command stream
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 7);
      val = $urandom_range(0, MOD - 1);
      pa  = -1;
      if (op == 6 && $urandom_range(0, 2) == 0) pa = $urandom_range(2, 6);
      run_cmd(op, val, pa, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
